// File: rtl/hit_memory_readout_if.sv
// Bundles the readout engine's command, HNM spare-port and hit-stream signals.
// master = readout engine, slave = storage path / HNM / hit consumer side.
interface hit_memory_readout_if #(
    parameter int COLINDEXBITS     = 5,
    parameter int ROWINDEXBITS_HNM = 6
);
    localparam int ROWW  = 2 ** COLINDEXBITS;
    localparam int ADDRW = ROWINDEXBITS_HNM + COLINDEXBITS;

    logic                        startReadout;
    logic                        clearAfterRead;
    logic                        readoutBusy;
    logic                        readoutDone;
    logic [ROWINDEXBITS_HNM-1:0] memAddr;
    logic                        memWriteEnable;
    logic [ROWW-1:0]             memDataIn;
    logic [ROWW-1:0]             memDataOut;
    logic [ADDRW-1:0]            hitAddress;
    logic                        hitValid;
    logic                        hitReady;
    logic [ADDRW:0]              nHitsRead;

    modport master (
        input  startReadout, clearAfterRead, memDataOut, hitReady,
        output readoutBusy, readoutDone, memAddr, memWriteEnable, memDataIn,
               hitAddress, hitValid, nHitsRead
    );

    modport slave (
        output startReadout, clearAfterRead, memDataOut, hitReady,
        input  readoutBusy, readoutDone, memAddr, memWriteEnable, memDataIn,
               hitAddress, hitValid, nHitsRead
    );
endinterface

// File: rtl/hit_memory_readout.sv
// Scans all HNM rows over the spare port and streams one {row,col} per stored hit, lowest col first.
// Latency: 3 cycles per empty row, 3+k per row with k hits (+1 if clearing); hitValid holds until accepted.
module hit_memory_readout #(
    parameter int COLINDEXBITS     = 5,
    parameter int ROWINDEXBITS_HNM = 6,
    parameter int MEMNROWS_HNM     = 64,
    parameter int ADDRESSNBITS     = ROWINDEXBITS_HNM + COLINDEXBITS
) (
    input  logic                 clock,
    input  logic                 resetN,
    hit_memory_readout_if.master bus
);
    localparam int ROWW = 2 ** COLINDEXBITS;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_SCAN, S_CLEAR, S_NEXT, S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [ROWINDEXBITS_HNM-1:0] row_q, row_d;
    logic [ROWW-1:0]             row_bits_q, row_bits_d;
    logic                        clr_q, clr_d;
    logic [ADDRESSNBITS:0]       n_hits_q, n_hits_d;
    logic [COLINDEXBITS-1:0]     low_idx;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            row_bits_q <= '0;
            clr_q      <= 1'b0;
            n_hits_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_bits_q <= row_bits_d;
            clr_q      <= clr_d;
            n_hits_q   <= n_hits_d;
        end
    end

    // Priority search from the top down so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = ROWW - 1; i >= 0; i--) begin
            if (row_bits_q[i]) low_idx = COLINDEXBITS'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        row_bits_d = row_bits_q;
        clr_d      = clr_q;
        n_hits_d   = n_hits_q;
        case (state_q)
            S_IDLE: begin
                if (bus.startReadout) begin
                    row_d    = '0;
                    n_hits_d = '0;
                    clr_d    = bus.clearAfterRead;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                row_bits_d = bus.memDataOut;
                state_d    = (bus.memDataOut != '0) ? S_SCAN : S_NEXT;
            end
            S_SCAN: begin
                if (bus.hitReady) begin
                    row_bits_d = row_bits_q & (row_bits_q - 1'b1);
                    n_hits_d   = n_hits_q + 1'b1;
                    if (row_bits_d == '0) state_d = clr_q ? S_CLEAR : S_NEXT;
                end
            end
            S_CLEAR: state_d = S_NEXT;
            S_NEXT: begin
                if (row_q == ROWINDEXBITS_HNM'(MEMNROWS_HNM - 1)) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs decode from registered state, so reset forces them low immediately.
    assign bus.readoutBusy    = (state_q != S_IDLE);
    assign bus.readoutDone    = (state_q == S_DONE);
    assign bus.memAddr        = row_q;
    assign bus.memWriteEnable = (state_q == S_CLEAR);
    assign bus.memDataIn      = '0;
    assign bus.hitValid       = (state_q == S_SCAN);
    assign bus.hitAddress     = (state_q == S_SCAN) ? {row_q, low_idx} : '0;
    assign bus.nHitsRead      = n_hits_q;
endmodule

// File: tb/tb_hit_memory_readout.sv
// Randomized bench for hit_memory_readout: behavioural HNM, hit/write/done monitor,
// and a row-by-row reference model of expected hits, writes and scan length.
module tb_hit_memory_readout;
    logic clock;
    logic resetN;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ready_mode = 0;

    hit_memory_readout_if #(.COLINDEXBITS(5), .ROWINDEXBITS_HNM(6)) bus ();

    hit_memory_readout #(.COLINDEXBITS(5), .ROWINDEXBITS_HNM(6), .MEMNROWS_HNM(64),
                         .ADDRESSNBITS(11)) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // HNM model: synchronous read, data one cycle after address is sampled.
    logic [31:0] hnm [64];
    logic [31:0] rd_q;
    always @(posedge clock) begin
        rd_q <= hnm[bus.memAddr];
        if (bus.memWriteEnable) hnm[bus.memAddr] = bus.memDataIn;
    end
    assign bus.memDataOut = rd_q;

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.hitReady = 1'b1;
            1:       bus.hitReady = 1'($urandom_range(0, 1));
            default: bus.hitReady = 1'b0;
        endcase
    end

    int   got_hits[$], got_hit_cyc[$], got_wr[$], done_cyc[$];
    int   wdata_err, stab_err, hv_cnt;
    logic pv, pr;
    logic [10:0] pa;

    always @(negedge clock) begin
        if (!resetN) begin
            pv = 1'b0;
        end else begin
            if (bus.hitValid) hv_cnt++;
            if (bus.hitValid && bus.hitReady) begin
                got_hits.push_back(int'(bus.hitAddress));
                got_hit_cyc.push_back(cyc);
            end
            if (bus.memWriteEnable) begin
                got_wr.push_back(int'(bus.memAddr));
                if (bus.memDataIn !== 32'h0) wdata_err++;
            end
            if (bus.readoutDone) done_cyc.push_back(cyc - start_cyc + 1);
            if (pv && !pr && (!bus.hitValid || bus.hitAddress !== pa)) stab_err++;
            pv = bus.hitValid;
            pr = bus.hitReady;
            pa = bus.hitAddress;
        end
    end

    int exp_hits[$], exp_wr[$];
    int exp_cycles;
    logic [31:0] exp_mem [64];

    // Expected results straight from the memory image: hits in row-major order.
    function automatic void build_expected(input bit clr);
        int k;
        exp_hits.delete();
        exp_wr.delete();
        exp_cycles = 1;
        for (int r = 0; r < 64; r++) begin
            k = 0;
            for (int c = 0; c < 32; c++) begin
                if (hnm[r][c]) begin
                    exp_hits.push_back(r * 32 + c);
                    k++;
                end
            end
            exp_cycles += 3 + k;
            exp_mem[r] = hnm[r];
            if (clr && k > 0) begin
                exp_cycles++;
                exp_wr.push_back(r);
                exp_mem[r] = 32'h0;
            end
        end
    endfunction

    task automatic start_scan(input bit clr);
        got_hits.delete(); got_hit_cyc.delete(); got_wr.delete(); done_cyc.delete();
        wdata_err = 0; stab_err = 0; hv_cnt = 0;
        @(negedge clock);
        bus.startReadout   = 1'b1;
        bus.clearAfterRead = clr;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        bus.startReadout = 1'b0;
    endtask

    task automatic wait_done(input bit inject, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clock);
            #1;
            bus.clearAfterRead = 1'($urandom_range(0, 1));
            bus.startReadout   = inject && (i == 20 || i == 90);
            if (done_cyc.size() > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.startReadout = 1'b0;
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic compare_hits(input string name);
        n_cmp++;
        if (got_hits.size() !== exp_hits.size()) begin
            n_bad++;
            $display("FAIL %s hit count: got %0d expected %0d", name, got_hits.size(), exp_hits.size());
        end
        for (int i = 0; i < got_hits.size() && i < exp_hits.size(); i++) begin
            n_cmp++;
            if (got_hits[i] !== exp_hits[i]) begin
                n_bad++;
                $display("FAIL %s hit[%0d]: got %0d expected %0d", name, i, got_hits[i], exp_hits[i]);
            end
        end
    endtask

    task automatic clear_mem();
        for (int r = 0; r < 64; r++) hnm[r] = 32'h0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.startReadout = 1'b0;
        bus.clearAfterRead = 1'b0;
        clear_mem();
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({bus.readoutBusy, bus.readoutDone, bus.hitValid, bus.memWriteEnable} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset flags: got %b expected 0000",
                     {bus.readoutBusy, bus.readoutDone, bus.hitValid, bus.memWriteEnable});
        end
        n_cmp++;
        if ({bus.memAddr, bus.hitAddress, bus.nHitsRead} !== 29'h0) begin
            n_bad++;
            $display("FAIL reset buses: got addr=%0d hit=%0d n=%0d expected 0",
                     bus.memAddr, bus.hitAddress, bus.nHitsRead);
        end
        resetN = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_empty();
        bit to;
        clear_mem();
        ready_mode = 0;
        build_expected(1'b0);
        start_scan(1'b0);
        wait_done(1'b1, to);
        n_cmp++;
        if (to || done_cyc.size() !== 1) begin
            n_bad++;
            $display("FAIL empty done pulses: got %0d expected 1", done_cyc.size());
        end else begin
            n_cmp++;
            if (done_cyc[0] !== 193) begin
                n_bad++;
                $display("FAIL empty done cycle: got %0d expected 193", done_cyc[0]);
            end
        end
        n_cmp++;
        if (hv_cnt !== 0 || got_wr.size() !== 0) begin
            n_bad++;
            $display("FAIL empty activity: got valid=%0d writes=%0d expected 0 0", hv_cnt, got_wr.size());
        end
        n_cmp++;
        if (bus.nHitsRead !== 12'd0 || bus.readoutBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL empty end: got n=%0d busy=%b expected 0 0", bus.nHitsRead, bus.readoutBusy);
        end
    endtask

    task automatic test_single_hit();
        bit to;
        clear_mem();
        hnm[3] = 32'h0000_0080;
        ready_mode = 0;
        build_expected(1'b0);
        start_scan(1'b0);
        wait_done(1'b0, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL single timeout: got no done expected done");
        end
        compare_hits("single");
        n_cmp++;
        if (bus.nHitsRead !== 12'd1) begin
            n_bad++;
            $display("FAIL single nHitsRead: got %0d expected 1", bus.nHitsRead);
        end
    endtask

    task automatic test_last_row();
        bit to;
        clear_mem();
        hnm[63] = 32'h8000_0001;
        ready_mode = 0;
        build_expected(1'b0);
        start_scan(1'b0);
        wait_done(1'b0, to);
        compare_hits("row63");
        n_cmp++;
        if (got_hit_cyc.size() !== 2 || got_hit_cyc[1] - got_hit_cyc[0] !== 1) begin
            n_bad++;
            $display("FAIL row63 back_to_back: got %0d hits not consecutive expected 2 consecutive",
                     got_hit_cyc.size());
        end
        n_cmp++;
        if (to || done_cyc.size() !== 1 || done_cyc[0] !== exp_cycles) begin
            n_bad++;
            $display("FAIL row63 done: got %0d pulses expected 1 at cycle %0d", done_cyc.size(), exp_cycles);
        end
    endtask

    task automatic test_stall();
        bit to;
        bit seen;
        clear_mem();
        hnm[63] = 32'h8000_0001;
        ready_mode = 2;
        build_expected(1'b0);
        start_scan(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            #1;
            seen = bus.hitValid;
        end
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (bus.hitValid !== 1'b1 || bus.hitAddress !== 11'd2016) begin
                n_bad++;
                $display("FAIL stall hold[%0d]: got valid=%b addr=%0d expected 1 2016",
                         j, bus.hitValid, bus.hitAddress);
            end
            if (j == 4) ready_mode = 0;
            @(negedge clock);
            #1;
        end
        wait_done(1'b0, to);
        compare_hits("stall");
        n_cmp++;
        if (to || stab_err !== 0) begin
            n_bad++;
            $display("FAIL stall stability: got %0d drops expected 0", stab_err);
        end
    endtask

    task automatic test_clear();
        bit to;
        clear_mem();
        hnm[0]  = 32'h1 | $urandom;
        hnm[10] = 32'h8 | $urandom;
        ready_mode = 0;
        build_expected(1'b1);
        start_scan(1'b1);
        wait_done(1'b1, to);
        compare_hits("clear");
        n_cmp++;
        if (to || got_wr.size() !== 2 || got_wr[0] !== 0 || got_wr[1] !== 10) begin
            n_bad++;
            $display("FAIL clear writes: got %0d writes expected rows 0,10", got_wr.size());
        end
        n_cmp++;
        if (wdata_err !== 0 || hnm[0] !== 32'h0 || hnm[10] !== 32'h0) begin
            n_bad++;
            $display("FAIL clear data: got row0=%h row10=%h expected 0 0", hnm[0], hnm[10]);
        end
        build_expected(1'b0);
        start_scan(1'b0);
        wait_done(1'b0, to);
        n_cmp++;
        if (to || bus.nHitsRead !== 12'd0 || got_wr.size() !== 0) begin
            n_bad++;
            $display("FAIL clear rescan: got n=%0d writes=%0d expected 0 0", bus.nHitsRead, got_wr.size());
        end
    endtask

    task automatic test_random();
        bit to;
        bit clr;
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < 64; r++)
                hnm[r] = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
            clr = 1'($urandom_range(0, 1));
            ready_mode = it % 2;
            build_expected(clr);
            start_scan(clr);
            wait_done(1'b1, to);
            compare_hits("random");
            n_cmp++;
            if (to || done_cyc.size() !== 1) begin
                n_bad++;
                $display("FAIL random done pulses it%0d: got %0d expected 1", it, done_cyc.size());
            end else if (ready_mode == 0) begin
                n_cmp++;
                if (done_cyc[0] !== exp_cycles) begin
                    n_bad++;
                    $display("FAIL random timing it%0d: got %0d expected %0d", it, done_cyc[0], exp_cycles);
                end
            end
            n_cmp++;
            if (int'(bus.nHitsRead) !== exp_hits.size() || stab_err !== 0) begin
                n_bad++;
                $display("FAIL random count it%0d: got n=%0d drops=%0d expected %0d 0",
                         it, bus.nHitsRead, stab_err, exp_hits.size());
            end
            n_cmp++;
            if (got_wr != exp_wr || wdata_err !== 0 || hnm != exp_mem) begin
                n_bad++;
                $display("FAIL random writes it%0d: got %0d writes expected %0d", it, got_wr.size(), exp_wr.size());
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen;
        clear_mem();
        hnm[0] = 32'h0000_0001;
        hnm[5] = 32'h0000_0030;
        ready_mode = 0;
        start_scan(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            seen = bus.hitValid && (bus.hitAddress[10:5] == 6'd5);
        end
        resetN = 1'b0;
        #1;
        n_cmp++;
        if (!seen || {bus.readoutBusy, bus.readoutDone, bus.hitValid, bus.memWriteEnable} !== 4'b0 ||
            {bus.memAddr, bus.hitAddress, bus.nHitsRead} !== 29'h0) begin
            n_bad++;
            $display("FAIL midreset outputs: got busy=%b vld=%b addr=%0d n=%0d expected all 0",
                     bus.readoutBusy, bus.hitValid, bus.memAddr, bus.nHitsRead);
        end
        repeat (4) @(negedge clock);
        n_cmp++;
        if (done_cyc.size() !== 0 || got_wr.size() !== 1 || hnm[5] !== 32'h30) begin
            n_bad++;
            $display("FAIL midreset aftermath: got done=%0d writes=%0d row5=%h expected 0 1 30",
                     done_cyc.size(), got_wr.size(), hnm[5]);
        end
        resetN = 1'b1;
        @(negedge clock);
        build_expected(1'b0);
        start_scan(1'b0);
        wait_done(1'b0, to);
        compare_hits("midreset_rescan");
        n_cmp++;
        if (to || bus.nHitsRead !== 12'd2) begin
            n_bad++;
            $display("FAIL midreset rescan count: got %0d expected 2", bus.nHitsRead);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_hit();
        test_last_row();
        test_stall();
        test_clear();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
